// File: rtl/imm_gen_pipe_pkg.sv
// Shared immediate-format selector encodings for the immediate generator slice.
package imm_gen_pipe_pkg;

    typedef enum logic [2:0] {
        IMM_SEL_I     = 3'd0,
        IMM_SEL_S     = 3'd1,
        IMM_SEL_B     = 3'd2,
        IMM_SEL_J     = 3'd3,
        IMM_SEL_U     = 3'd4,
        IMM_SEL_SHAMT = 3'd5,
        IMM_SEL_ZIMM  = 3'd6,
        IMM_SEL_NONE  = 3'd7
    } imm_sel_e;

    localparam int IMM_SKID_DEPTH = 2;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Decode-side and execute-side handshake bundle of the pipelined immediate generator.
interface imm_gen_pipe_if #(
    parameter int XLEN = 32
);
    // Valid/ready: a transfer happens on a rising edge where valid && ready; valid must
    // not depend on ready, and Flush discards the in-flight input and all held entries.
    logic            In_Valid;
    logic            In_Ready;
    logic [31:0]     Instruction;
    logic [2:0]      Imm_Sel;
    logic            Flush;
    logic            Out_Valid;
    logic            Out_Ready;
    logic [XLEN-1:0] Imm_Gen_Out;
    logic            Imm_Err;

    modport slave (
        input  In_Valid, Instruction, Imm_Sel, Flush, Out_Ready,
        output In_Ready, Out_Valid, Imm_Gen_Out, Imm_Err
    );

    modport master (
        output In_Valid, Instruction, Imm_Sel, Flush, Out_Ready,
        input  In_Ready, Out_Valid, Imm_Gen_Out, Imm_Err
    );
endinterface

// File: rtl/imm_gen_pipe_core.sv
// Combinational immediate extraction for all RV base formats (imm_gen_core).
// IMM_GEN_ILLEGAL_CHK_EN adds the malformed-immediate flag output.
module imm_gen_core
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    input  logic [2:0]      i_sel,
`ifdef IMM_GEN_ILLEGAL_CHK_EN
    output logic            o_err,
`endif
    output logic [XLEN-1:0] o_imm
);

    logic [31:0] w_raw;
    logic        w_sext;
    logic [6:0]  w_unused;

    assign w_unused = i_instr[6:0];

    // Every format fits in 32 bits; only the sign-extending ones widen for XLEN=64.
    always_comb begin
        w_raw  = '0;
        w_sext = 1'b0;
        case (imm_sel_e'(i_sel))
            IMM_SEL_I: begin
                w_raw  = {{21{i_instr[31]}}, i_instr[30:20]};
                w_sext = 1'b1;
            end
            IMM_SEL_S: begin
                w_raw  = {{21{i_instr[31]}}, i_instr[30:25], i_instr[11:7]};
                w_sext = 1'b1;
            end
            IMM_SEL_B: begin
                w_raw  = {{20{i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
                w_sext = 1'b1;
            end
            IMM_SEL_J: begin
                w_raw  = {{12{i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
                w_sext = 1'b1;
            end
            IMM_SEL_U: begin
                w_raw  = {i_instr[31:12], 12'b0};
                w_sext = 1'b1;
            end
            IMM_SEL_SHAMT: begin
                if (XLEN == 64) w_raw = {26'b0, i_instr[25:20]};
                else            w_raw = {27'b0, i_instr[24:20]};
            end
            IMM_SEL_ZIMM: w_raw = {27'b0, i_instr[19:15]};
            default:      w_raw = '0;
        endcase
    end

    generate
        if (XLEN == 64) begin : g_x64
            assign o_imm = {{32{w_sext & w_raw[31]}}, w_raw};
        end else begin : g_x32
            assign o_imm = w_raw;
        end
    endgenerate

`ifdef IMM_GEN_ILLEGAL_CHK_EN
    assign o_err = (imm_sel_e'(i_sel) == IMM_SEL_NONE) ||
                   ((XLEN == 32) && (imm_sel_e'(i_sel) == IMM_SEL_SHAMT) && i_instr[25]);
`endif

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: one-cycle latency, main + skid register, flush.
// Optional IMM_GEN_ILLEGAL_CHK_EN carries a malformed-immediate flag with each entry.
module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic          Clk,
    input  logic          Rst_N,
    imm_gen_pipe_if.slave bus
);

    logic [XLEN-1:0] w_new_imm;
    logic            w_acc;
    logic            w_drain;
    logic            w_main_free;
    logic            w_main_load_skid;
    logic            w_main_load_in;
    logic            w_skid_load;

    logic            r_main_valid;
    logic            r_skid_valid;
    logic [XLEN-1:0] r_main_imm;
    logic [XLEN-1:0] r_skid_imm;

`ifdef IMM_GEN_ILLEGAL_CHK_EN
    logic w_new_err;
    logic r_main_err;
    logic r_skid_err;

    imm_gen_core #(.XLEN(XLEN)) u_core (
        .i_instr (bus.Instruction),
        .i_sel   (bus.Imm_Sel),
        .o_err   (w_new_err),
        .o_imm   (w_new_imm)
    );
`else
    imm_gen_core #(.XLEN(XLEN)) u_core (
        .i_instr (bus.Instruction),
        .i_sel   (bus.Imm_Sel),
        .o_imm   (w_new_imm)
    );
`endif

    // The skid only fills while main is held, so a free skid is exactly the ready condition.
    assign bus.In_Ready    = ~r_skid_valid;
    assign bus.Out_Valid   = r_main_valid;
    assign bus.Imm_Gen_Out = r_main_imm;

    assign w_acc            = bus.In_Valid && !r_skid_valid;
    assign w_drain          = r_main_valid && bus.Out_Ready;
    assign w_main_free      = !r_main_valid || w_drain;
    assign w_main_load_skid = w_main_free && r_skid_valid;
    assign w_main_load_in   = w_main_free && !r_skid_valid && w_acc;
    assign w_skid_load      = w_acc && !w_main_free;

    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (bus.Flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else begin
            if (w_main_free) r_main_valid <= r_skid_valid || w_acc;
            if (r_skid_valid) r_skid_valid <= !w_drain;
            else              r_skid_valid <= w_skid_load;
        end
    end

    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            r_main_imm <= '0;
            r_skid_imm <= '0;
        end else if (!bus.Flush) begin
            if (w_main_load_skid)    r_main_imm <= r_skid_imm;
            else if (w_main_load_in) r_main_imm <= w_new_imm;
            if (w_skid_load)         r_skid_imm <= w_new_imm;
        end
    end

`ifdef IMM_GEN_ILLEGAL_CHK_EN
    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            r_main_err <= 1'b0;
            r_skid_err <= 1'b0;
        end else if (!bus.Flush) begin
            if (w_main_load_skid)    r_main_err <= r_skid_err;
            else if (w_main_load_in) r_main_err <= w_new_err;
            if (w_skid_load)         r_skid_err <= w_new_err;
        end
    end

    assign bus.Imm_Err = r_main_err;
`else
    assign bus.Imm_Err = 1'b0;
`endif

endmodule
